// File: rtl/conv_forward_stream_if.sv
// Beat and result handshake bundle for conv_forward_stream.
// The feeder/consumer side uses the master modport; the neuron uses the slave modport.
interface conv_forward_stream_if #(
  parameter int WIDTH  = 8,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0][DATA_W-1:0]  in_data;
  logic [WIDTH-1:0][DATA_W-1:0]  weight_vec;
  logic [DATA_W-1:0]             bias_term;
  logic                          relu_en;
  logic [ID_W-1:0]               id;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [ID_W-1:0]               out_id;

  modport master (
    output in_valid, in_data, weight_vec, bias_term, relu_en, id, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  in_valid, in_data, weight_vec, bias_term, relu_en, id, out_ready,
    output in_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/conv_forward_stream.sv
// Streaming fixed-point neuron: per-beat lane products, registered adder tree, kernel
// accumulator, then bias/round/saturate/ReLU; the whole pipeline freezes while the result is stalled.
module conv_forward_stream #(
  parameter int WIDTH     = 8,
  parameter int NUM_BEATS = 2,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int ID_W      = 8
) (
  input logic                  clk,
  input logic                  reset,
  conv_forward_stream_if.slave bus
);
  localparam int LOG_W  = $clog2(WIDTH);
  localparam int NODES  = 2 * WIDTH - 1;
  localparam int TREE_W = 2 * DATA_W + LOG_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(WIDTH * NUM_BEATS) + 1;
  localparam int RND_W  = ACC_W + 1;
  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [RND_W-1:0] HALF = RND_W'(1'b1) << (FRAC_W - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic stall_s, adv_s, accept_s;
  logic [BEAT_W-1:0] beat_q, beat_d;
  // Heap-ordered tree: leaves WIDTH-1..NODES-1 hold products, node 0 is the beat sum.
  logic signed [TREE_W-1:0] node_q [NODES];
  logic signed [TREE_W-1:0] node_d [NODES];
  logic signed [TREE_W-1:0] prod_s [WIDTH];
  logic vld_q [LOG_W+1], vld_d [LOG_W+1], first_q [LOG_W+1], first_d [LOG_W+1];
  logic last_q [LOG_W+1], last_d [LOG_W+1], relu_q [LOG_W+1], relu_d [LOG_W+1];
  logic [DATA_W-1:0] bias_q [LOG_W+1], bias_d [LOG_W+1];
  logic [ID_W-1:0]   id_q [LOG_W+1], id_d [LOG_W+1];
  logic signed [ACC_W-1:0] acc_q, acc_d, root_ext_s;
  logic acc_vld_q, acc_vld_d, acc_relu_q, acc_relu_d;
  logic [DATA_W-1:0] acc_bias_q, acc_bias_d;
  logic [ID_W-1:0]   acc_id_q, acc_id_d;
  logic signed [RND_W-1:0] rnd_q, rnd_d, rnd_sum_s, bias_ext_s;
  logic rnd_vld_q, rnd_vld_d, rnd_relu_q, rnd_relu_d;
  logic [ID_W-1:0]   rnd_id_q, rnd_id_d;
  logic [DATA_W-1:0] sat_s, out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic out_vld_q, out_vld_d;

  assign stall_s       = out_vld_q & ~bus.out_ready;
  assign adv_s         = ~stall_s;
  assign bus.in_ready  = reset & ~stall_s;
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic signed [TREE_W-1:0] a_s, b_s;
    assign a_s       = {{(TREE_W-DATA_W){bus.in_data[g][DATA_W-1]}}, bus.in_data[g]};
    assign b_s       = {{(TREE_W-DATA_W){bus.weight_vec[g][DATA_W-1]}}, bus.weight_vec[g]};
    assign prod_s[g] = a_s * b_s;
  end

  // Next-state for every pipeline stage
  always_comb begin
    beat_d = beat_q;
    if (accept_s) begin
      if (beat_q == BEAT_W'(NUM_BEATS - 1)) beat_d = {BEAT_W{1'b0}};
      else                                  beat_d = beat_q + BEAT_W'(1'b1);
    end else begin
      beat_d = beat_q;
    end
    for (int i = 0; i < WIDTH; i++)     node_d[WIDTH-1+i] = prod_s[i];
    for (int i = 0; i < WIDTH - 1; i++) node_d[i] = node_q[2*i+1] + node_q[2*i+2];
    vld_d[0]   = accept_s;
    first_d[0] = (beat_q == {BEAT_W{1'b0}});
    last_d[0]  = (beat_q == BEAT_W'(NUM_BEATS - 1));
    relu_d[0]  = bus.relu_en;
    bias_d[0]  = bus.bias_term;
    id_d[0]    = bus.id;
    for (int s = 1; s <= LOG_W; s++) begin
      vld_d[s]   = vld_q[s-1];
      first_d[s] = first_q[s-1];
      last_d[s]  = last_q[s-1];
      relu_d[s]  = relu_q[s-1];
      bias_d[s]  = bias_q[s-1];
      id_d[s]    = id_q[s-1];
    end
    root_ext_s = {{(ACC_W-TREE_W){node_q[0][TREE_W-1]}}, node_q[0]};
    acc_d      = acc_q;
    if (vld_q[LOG_W]) begin
      if (first_q[LOG_W]) acc_d = root_ext_s;
      else                acc_d = acc_q + root_ext_s;
    end else begin
      acc_d = acc_q;
    end
    acc_vld_d  = vld_q[LOG_W] & last_q[LOG_W];
    acc_relu_d = relu_q[LOG_W];
    acc_bias_d = bias_q[LOG_W];
    acc_id_d   = id_q[LOG_W];
    bias_ext_s = {{(RND_W-DATA_W-FRAC_W){acc_bias_q[DATA_W-1]}}, acc_bias_q, {FRAC_W{1'b0}}};
    rnd_sum_s  = {acc_q[ACC_W-1], acc_q} + bias_ext_s + HALF;
    rnd_d      = rnd_sum_s >>> FRAC_W;
    rnd_vld_d  = acc_vld_q;
    rnd_relu_d = acc_relu_q;
    rnd_id_d   = acc_id_q;
    if (rnd_q > SAT_MAX)      sat_s = {1'b0, {(DATA_W-1){1'b1}}};
    else if (rnd_q < SAT_MIN) sat_s = {1'b1, {(DATA_W-1){1'b0}}};
    else                      sat_s = rnd_q[DATA_W-1:0];
    out_vld_d  = rnd_vld_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (rnd_vld_q) begin
      out_id_d = rnd_id_q;
      if (rnd_relu_q && sat_s[DATA_W-1]) out_data_d = {DATA_W{1'b0}};
      else                               out_data_d = sat_s;
    end else begin
      out_id_d = out_id_q;
    end
  end

  // Pipeline registers: cleared by reset, frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q <= {BEAT_W{1'b0}};
      for (int i = 0; i < NODES; i++) node_q[i] <= {TREE_W{1'b0}};
      for (int s = 0; s <= LOG_W; s++) begin
        vld_q[s]   <= 1'b0;
        first_q[s] <= 1'b0;
        last_q[s]  <= 1'b0;
        relu_q[s]  <= 1'b0;
        bias_q[s]  <= {DATA_W{1'b0}};
        id_q[s]    <= {ID_W{1'b0}};
      end
      acc_q      <= {ACC_W{1'b0}};
      acc_vld_q  <= 1'b0;
      acc_relu_q <= 1'b0;
      acc_bias_q <= {DATA_W{1'b0}};
      acc_id_q   <= {ID_W{1'b0}};
      rnd_q      <= {RND_W{1'b0}};
      rnd_vld_q  <= 1'b0;
      rnd_relu_q <= 1'b0;
      rnd_id_q   <= {ID_W{1'b0}};
      out_vld_q  <= 1'b0;
      out_data_q <= {DATA_W{1'b0}};
      out_id_q   <= {ID_W{1'b0}};
    end else if (adv_s) begin
      beat_q     <= beat_d;
      node_q     <= node_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
      relu_q     <= relu_d;
      bias_q     <= bias_d;
      id_q       <= id_d;
      acc_q      <= acc_d;
      acc_vld_q  <= acc_vld_d;
      acc_relu_q <= acc_relu_d;
      acc_bias_q <= acc_bias_d;
      acc_id_q   <= acc_id_d;
      rnd_q      <= rnd_d;
      rnd_vld_q  <= rnd_vld_d;
      rnd_relu_q <= rnd_relu_d;
      rnd_id_q   <= rnd_id_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end
endmodule

// File: tb/tb_conv_forward_stream.sv
// Randomised and directed bench for conv_forward_stream (WIDTH=8, NUM_BEATS=2, Q16.16),
// scored against an arithmetic reference model and a FIFO of expected results.
module tb_conv_forward_stream;
  localparam int W = 8, NB = 2, DW = 32, IW = 8;
  typedef logic [W-1:0][DW-1:0] vec_t;
  typedef logic [NB-1:0][W-1:0][DW-1:0] kern_t;
  typedef struct { logic [DW-1:0] data; logic [IW-1:0] id; } res_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0, n_fail = 0, rdy_mode = 0;
  res_t exp_q[$];

  conv_forward_stream_if #(.WIDTH(W), .DATA_W(DW), .ID_W(IW)) bus_if ();
  conv_forward_stream #(.WIDTH(W), .NUM_BEATS(NB), .DATA_W(DW), .FRAC_W(16), .ID_W(IW))
    u_dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input kern_t din, input kern_t w, input logic [DW-1:0] bias,
                                          input logic relu);
    logic signed [127:0] sum, a, b;
    sum = 128'sd0;
    for (int k = 0; k < NB; k++)
      for (int l = 0; l < W; l++) begin
        a = $signed(din[k][l]);
        b = $signed(w[k][l]);
        sum += a * b;
      end
    a = $signed(bias);
    sum = (sum + (a <<< 16) + 128'sd32768) >>> 16;
    if (sum > 128'sd2147483647) sum = 128'sd2147483647;
    if (sum < -128'sd2147483648) sum = -128'sd2147483648;
    if (relu && sum < 128'sd0) sum = 128'sd0;
    return sum[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_word();
    int s = $urandom_range(0, 4);
    case (s)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h0003_FFFF)) - 32'h0002_0000;
      2:       return ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom_range(0, 32'h0002_0000));
    endcase
  endfunction

  task automatic send_beat(input vec_t din, input vec_t w, input logic [DW-1:0] bias,
                           input logic relu, input logic [IW-1:0] tag);
    int n = 0;
    @(negedge clk); #1;
    bus_if.in_valid = 1'b1; bus_if.in_data = din; bus_if.weight_vec = w;
    bus_if.bias_term = bias; bus_if.relu_en = relu; bus_if.id = tag;
    while (!bus_if.in_ready && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 500) check_val("in_ready_wait", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic send_kernel(input kern_t din, input kern_t w, input logic [DW-1:0] bias,
                             input logic relu, input logic [IW-1:0] tag, input int gap_max,
                             input bit use_exp, input logic [DW-1:0] exp_data);
    res_t r;
    for (int k = 0; k < NB; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      if (k == NB - 1) send_beat(din[k], w[k], bias, relu, tag);
      else send_beat(din[k], w[k], $urandom, 1'($urandom_range(0, 1)), 8'($urandom));
    end
    r.data = use_exp ? exp_data : model(din, w, bias, relu);
    r.id   = tag;
    exp_q.push_back(r);
  endtask

  task automatic send_random(input logic [IW-1:0] tag, input int gap_max);
    kern_t din, w;
    for (int k = 0; k < NB; k++)
      for (int l = 0; l < W; l++) begin
        din[k][l] = rand_word();
        w[k][l]   = rand_word();
      end
    send_kernel(din, w, rand_word(), 1'($urandom_range(0, 1)), tag, gap_max, 1'b0, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = random, 2 = held off
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       bus_if.out_ready = 1'($urandom_range(0, 1));
        2:       bus_if.out_ready = 1'b0;
        default: bus_if.out_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard: every handshaken result must be the oldest outstanding expectation
  initial begin
    res_t r;
    forever begin
      @(negedge clk); #2;
      if (reset === 1'b1 && bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_out", 64'd1, 64'd0);
        else begin
          r = exp_q.pop_front();
          check_val("out_data", 64'(bus_if.out_data), 64'(r.data));
          check_val("out_id", 64'(bus_if.out_id), 64'(r.id));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    kern_t din, w;
    int n;
    reset = 1'b0;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.weight_vec = '0;
    bus_if.bias_term = '0; bus_if.relu_en = 1'b0; bus_if.id = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check_val("rst_out_data", 64'(bus_if.out_data), 64'd0);
    check_val("rst_out_id", 64'(bus_if.out_id), 64'd0);
    check_val("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    @(negedge clk); reset = 1'b1;

    // Unit weights, half-LSB bias; out_valid must appear exactly 6 edges after the last beat
    send_kernel({(NB*W){32'h0001_0000}}, {(NB*W){32'h0001_0000}}, 32'h0000_8000, 1'b0, 8'd5, 0,
                1'b1, 32'h0010_8000);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check_val("t1_latency", 64'(bus_if.out_valid), (c == 6) ? 64'd1 : 64'd0);
    end
    drain();

    send_kernel({(NB*W){32'h0001_0000}}, {(NB*W){32'hFFFF_0000}}, 32'h0, 1'b0, 8'd6, 1, 1'b1, 32'hFFF0_0000);
    send_kernel({(NB*W){32'h0001_0000}}, {(NB*W){32'hFFFF_0000}}, 32'h0, 1'b1, 8'd7, 1, 1'b1, 32'h0000_0000);
    send_kernel({(NB*W){32'h7FFF_FFFF}}, {(NB*W){32'h7FFF_FFFF}}, 32'h7FFF_FFFF, 1'b0, 8'd8, 0, 1'b1, 32'h7FFF_FFFF);
    send_kernel({(NB*W){32'h7FFF_FFFF}}, {(NB*W){32'h8000_0000}}, 32'h0, 1'b0, 8'd9, 0, 1'b1, 32'h8000_0000);
    din = '0; w = '0; din[0][0] = 32'h0000_0001; w[0][0] = 32'h0000_8000;
    send_kernel(din, w, 32'h0, 1'b0, 8'd10, 0, 1'b1, 32'h0000_0001);
    w[0][0] = 32'hFFFF_8000;
    send_kernel(din, w, 32'h0, 1'b0, 8'd11, 0, 1'b1, 32'h0000_0000);
    drain();

    // Three back-to-back kernels held off for 10 cycles after the first result appears
    rdy_mode = 2;
    for (int k = 1; k <= 3; k++) send_random(8'(k), 0);
    n = 0;
    while (!bus_if.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("t5_out_valid", 64'(bus_if.out_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #3;
      check_val("t5_in_ready", 64'(bus_if.in_ready), 64'd0);
      check_val("t5_hold_data", 64'(bus_if.out_data), 64'(exp_q[0].data));
      check_val("t5_hold_id", 64'(bus_if.out_id), 64'd1);
    end
    rdy_mode = 0;
    drain();

    // Reset right after beat 0: the partial kernel must vanish
    send_beat({W{32'h0001_0000}}, {W{32'h0001_0000}}, 32'h0, 1'b0, 8'd99);
    @(negedge clk); reset = 1'b0; #1;
    check_val("t6_in_ready_rst", 64'(bus_if.in_ready), 64'd0);
    @(negedge clk); reset = 1'b1;
    check_val("t6_out_data_rst", 64'(bus_if.out_data), 64'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_val("t6_no_out", 64'(bus_if.out_valid), 64'd0);
    end
    send_random(8'd42, 0);
    drain();

    // Random traffic with bubbles and random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) send_random(8'($urandom), 2);
    drain();
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
